// File: rtl/program_loader_pkg.sv
// Shared constants and FSM encodings for the boot program loader.
// LOADER_CHECKSUM_EN adds the CHECK state for the trailing XOR checksum byte.
package program_loader_pkg;

  localparam int BYTE_BITS            = 8;
  localparam int DEFAULT_ADDRESS_BITS = 8;
  localparam int DEFAULT_DATA_BITS    = 32;
  localparam int BYTES_PER_WORD       = DEFAULT_DATA_BITS / BYTE_BITS;

  // The default halt word is all ones; it is built by replicating this byte.
  localparam logic [BYTE_BITS-1:0] DEFAULT_HALT_BYTE = 8'hFF;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DONE  = 2'd3
  } state_t;
`endif

  function automatic int bytes_per_word(input int data_bits);
    return data_bits / BYTE_BITS;
  endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs a byte stream little-endian into words; word_done/word_data are combinational
// on the cycle the last lane byte is presented, so the parent can register the write.
module program_loader_word_assembler
  import program_loader_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 byte_valid,
  input  logic [BYTE_BITS-1:0] byte_data,
  output logic                 word_done,
  output logic [DATA_BITS-1:0] word_data
);

  localparam int BPW      = bytes_per_word(DATA_BITS);
  localparam int IDX_BITS = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IDX_BITS-1:0]  byte_idx;
  logic [DATA_BITS-1:0] lanes;

  // Merge the in-flight byte so the completed word is visible without a cycle of delay.
  always_comb begin
    word_data = lanes;
    word_data[byte_idx*BYTE_BITS +: BYTE_BITS] = byte_data;
    word_done = byte_valid && (byte_idx == IDX_BITS'(BPW - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx <= '0;
      lanes    <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      lanes    <= '0;
    end else if (byte_valid) begin
      if (word_done) begin
        byte_idx <= '0;
        lanes    <= '0;
      end else begin
        byte_idx <= byte_idx + 1'b1;
        lanes[byte_idx*BYTE_BITS +: BYTE_BITS] <= byte_data;
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: UART bytes -> little-endian words -> sequential BRAM writes, one cycle after the last byte.
// No backpressure; stops at HALT_WORD or full memory. LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int                   ADDRESS_BITS = DEFAULT_ADDRESS_BITS,
  parameter int                   DATA_BITS    = DEFAULT_DATA_BITS,
  parameter logic [DATA_BITS-1:0] HALT_WORD    = {(DATA_BITS/BYTE_BITS){DEFAULT_HALT_BYTE}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_rx_valid,
  input  logic [BYTE_BITS-1:0]    i_rx_data,
  output logic                    o_write_enable,
  output logic [ADDRESS_BITS-1:0] o_address,
  output logic [DATA_BITS-1:0]    o_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error,
  output logic [ADDRESS_BITS:0]   o_word_count
);

  state_t                  state;
  logic [ADDRESS_BITS-1:0] address;
  logic                    start_load;
  logic                    accept;
  logic                    word_done;
  logic [DATA_BITS-1:0]    word_data;
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_BITS-1:0]    checksum;
`endif

  // A byte arriving alongside i_start is dropped: only RECV accepts data.
  assign start_load = i_start && ((state == IDLE) || (state == DONE));
  assign accept     = i_rx_valid && (state == RECV);

  program_loader_word_assembler #(
    .DATA_BITS (DATA_BITS)
  ) u_word_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_load),
    .byte_valid (accept),
    .byte_data  (i_rx_data),
    .word_done  (word_done),
    .word_data  (word_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      address        <= '0;
      o_write_enable <= 1'b0;
      o_address      <= '0;
      o_data         <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_error        <= 1'b0;
      o_word_count   <= '0;
`ifdef LOADER_CHECKSUM_EN
      checksum       <= '0;
`endif
    end else begin
      o_write_enable <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_load) begin
            state        <= RECV;
            address      <= '0;
            o_word_count <= '0;
            o_busy       <= 1'b1;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum     <= '0;
`endif
          end
        end
        RECV: begin
`ifdef LOADER_CHECKSUM_EN
          if (accept) checksum <= checksum ^ i_rx_data;
`endif
          if (word_done) begin
            o_write_enable <= 1'b1;
            o_address      <= address;
            o_data         <= word_data;
            o_word_count   <= o_word_count + 1'b1;
            if (word_data == HALT_WORD) begin
`ifdef LOADER_CHECKSUM_EN
              state  <= CHECK;
`else
              state  <= DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
`endif
            end else if (address == '1) begin
              // Last address just written with no halt seen: overflow exit before any wrap.
              state   <= DONE;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
              o_error <= 1'b1;
            end else begin
              address <= address + 1'b1;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (i_rx_valid) begin
            state   <= DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            o_error <= (i_rx_data != checksum);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomised directed bench for program_loader: an 8-bit-address and a 2-bit-address instance share
// one byte stream, each checked against a word-level reference model of the load rules.
`timescale 1ns/1ps
module tb_program_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_start = 1'b0;
  logic       i_rx_valid = 1'b0;
  logic [7:0] i_rx_data = 8'h00;

  logic        we0, busy0, done0, err0;
  logic [7:0]  addr0;
  logic [31:0] data0;
  logic [8:0]  cnt0;
  logic        we1, busy1, done1, err1;
  logic [1:0]  addr1;
  logic [31:0] data1;
  logic [2:0]  cnt1;

  always #5 clk = ~clk;

  program_loader dut0 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_write_enable(we0), .o_address(addr0), .o_data(data0), .o_busy(busy0),
    .o_done(done0), .o_error(err0), .o_word_count(cnt0)
  );

  program_loader #(.ADDRESS_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_write_enable(we1), .o_address(addr1), .o_data(data1), .o_busy(busy1),
    .o_done(done1), .o_error(err1), .o_word_count(cnt1)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] obs0[$];
  logic [63:0] obs1[$];
  logic [63:0] exp0[$];
  logic [63:0] exp1[$];
  logic [7:0]  stim[$];
  bit          e_done[2];
  bit          e_err[2];
  int          e_halt[2];

  // Record every write strobe as {address, data}.
  always @(negedge clk) begin
    if (we0) obs0.push_back((64'(addr0) << 32) | 64'(data0));
    if (we1) obs1.push_back((64'(addr1) << 32) | 64'(data1));
  end

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: group bytes into little-endian words, write to ascending addresses,
  // stop at the halt word (then optionally one checksum byte) or after the last address.
  task automatic model(input int k, input int cap);
    logic [63:0] q[$];
    logic [31:0] w;
    logic [7:0]  x;
    int          lane, addr;
    bit          fin, in_chk;
    q = {}; w = '0; x = '0; lane = 0; addr = 0; fin = 0; in_chk = 0;
    e_done[k] = 0; e_err[k] = 0; e_halt[k] = -1;
    foreach (stim[i]) begin
      if (!fin) begin
        if (in_chk) begin
          fin = 1; e_done[k] = 1; e_err[k] = (stim[i] != x);
        end else begin
          x = x ^ stim[i];
          w[8*lane +: 8] = stim[i];
          lane++;
          if (lane == 4) begin
            q.push_back((64'(addr) << 32) | 64'(w));
            lane = 0;
            if (w == 32'hFFFF_FFFF) begin
              e_halt[k] = i;
              if (CSUM) in_chk = 1;
              else begin fin = 1; e_done[k] = 1; end
            end else if (addr == cap - 1) begin
              fin = 1; e_done[k] = 1; e_err[k] = 1;
            end else begin
              addr++;
            end
            w = '0;
          end
        end
      end
    end
    if (k == 0) exp0 = q; else exp1 = q;
  endtask

  task automatic check_result(input string name, input int k);
    logic [63:0] oq[$];
    logic [63:0] eq[$];
    logic        d, e, b;
    int          c;
    if (k == 0) begin oq = obs0; eq = exp0; d = done0; e = err0; b = busy0; c = int'(cnt0); end
    else        begin oq = obs1; eq = exp1; d = done1; e = err1; b = busy1; c = int'(cnt1); end
    chk($sformatf("%s_d%0d_nwrites", name, k), 64'(oq.size()), 64'(eq.size()));
    for (int i = 0; i < eq.size() && i < oq.size(); i++)
      chk($sformatf("%s_d%0d_write%0d", name, k, i), oq[i], eq[i]);
    chk($sformatf("%s_d%0d_done", name, k), 64'(d), 64'(e_done[k]));
    chk($sformatf("%s_d%0d_error", name, k), 64'(e), 64'(e_err[k]));
    chk($sformatf("%s_d%0d_busy", name, k), 64'(b), 64'(!e_done[k]));
    chk($sformatf("%s_d%0d_count", name, k), 64'(c), 64'(eq.size()));
  endtask

  task automatic check_zero(input string name);
    chk({name, "_we0"}, 64'(we0), 64'd0);    chk({name, "_we1"}, 64'(we1), 64'd0);
    chk({name, "_addr0"}, 64'(addr0), 64'd0); chk({name, "_addr1"}, 64'(addr1), 64'd0);
    chk({name, "_data0"}, 64'(data0), 64'd0); chk({name, "_data1"}, 64'(data1), 64'd0);
    chk({name, "_busy0"}, 64'(busy0), 64'd0); chk({name, "_busy1"}, 64'(busy1), 64'd0);
    chk({name, "_done0"}, 64'(done0), 64'd0); chk({name, "_done1"}, 64'(done1), 64'd0);
    chk({name, "_err0"}, 64'(err0), 64'd0);   chk({name, "_err1"}, 64'(err1), 64'd0);
    chk({name, "_cnt0"}, 64'(cnt0), 64'd0);   chk({name, "_cnt1"}, 64'(cnt1), 64'd0);
  endtask

  // collide: a junk byte rides with i_start; mid: pulse i_start in a gap before stim[mid].
  task automatic do_load(input string name, input int max_gap, input bit collide, input int mid);
    int g;
    model(0, 256);
    model(1, 4);
    @(negedge clk);
    obs0 = {}; obs1 = {};
    i_start = 1'b1; i_rx_valid = collide; i_rx_data = 8'hFF;
    @(negedge clk);
    i_start = 1'b0; i_rx_valid = 1'b0;
    chk({name, "_start_done0"}, 64'(done0), 64'd0);
    chk({name, "_start_busy0"}, 64'(busy0), 64'd1);
    chk({name, "_start_done1"}, 64'(done1), 64'd0);
    chk({name, "_start_busy1"}, 64'(busy1), 64'd1);
    foreach (stim[i]) begin
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      if (i == mid && g == 0) g = 1;
      for (int j = 0; j < g; j++) begin
        i_rx_valid = 1'b0;
        i_start = (i == mid && j == 0);
        @(negedge clk);
        i_start = 1'b0;
      end
      i_rx_valid = 1'b1; i_rx_data = stim[i];
      @(negedge clk);
      if (i == e_halt[0]) begin
        chk({name, "_halt_we0"}, 64'(we0), 64'd1);
        chk({name, "_halt_done0"}, 64'(done0), 64'(!CSUM));
        chk({name, "_halt_busy0"}, 64'(busy0), 64'(CSUM));
      end
      if (i == e_halt[1]) chk({name, "_halt_we1"}, 64'(we1), 64'd1);
    end
    i_rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_result(name, 0);
    check_result(name, 1);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) stim.push_back(w[8*b +: 8]);
  endtask

  task automatic push_checksum(input bit corrupt);
    logic [7:0] x;
    x = '0;
    foreach (stim[i]) x = x ^ stim[i];
    stim.push_back(corrupt ? (x ^ 8'h03) : x);
  endtask

  task automatic plan_stream();
    stim = {};
    push_word(32'h1234_5678);
    push_word(32'hDEAD_BEEF);
    push_word(32'hFFFF_FFFF);
    push_checksum(1'b0);
  endtask

  initial begin
    logic [31:0] w;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    plan_stream();
    do_load("plan", 0, 1'b0, -1);

    plan_stream();
    do_load("gaps", 5, 1'b1, 2);

    stim = {};
    push_word(32'h0000_0001);
    push_word(32'hFFFF_FFFF);
    stim.push_back(8'h01);
    do_load("csum_ok", 0, 1'b0, -1);
    stim[8] = 8'h02;
    do_load("csum_bad", 2, 1'b0, 5);

    // Six data words: the 2-bit instance overflows after four, the wide one takes them all.
    stim = {};
    for (int n = 0; n < 6; n++) begin
      w = $urandom;
      if (w == 32'hFFFF_FFFF) w = 32'h0;
      push_word(w);
    end
    push_word(32'hFFFF_FFFF);
    push_checksum(1'b0);
    do_load("overflow", 3, 1'b0, 1);

    for (int r = 0; r < 4; r++) begin
      stim = {};
      for (int n = 0; n < int'($urandom_range(0, 3)); n++) begin
        w = $urandom;
        if (w == 32'hFFFF_FFFF) w = 32'h1;
        push_word(w);
      end
      push_word(32'hFFFF_FFFF);
      push_checksum(r[0]);
      do_load($sformatf("rand%0d", r), r, r[1], -1);
    end

    // Reset after two bytes of the first word: no write, all outputs back to zero.
    @(negedge clk);
    obs0 = {}; obs1 = {};
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_rx_valid = 1'b1; i_rx_data = 8'h11;
    @(negedge clk);
    i_rx_data = 8'h22;
    @(negedge clk);
    i_rx_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_zero("midrst");
    chk("midrst_nwrites0", 64'(obs0.size()), 64'd0);
    chk("midrst_nwrites1", 64'(obs1.size()), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    plan_stream();
    do_load("after_rst", 1, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader sitting directly upstream of the instruction BRAM in the datapath. It takes a byte stream from the UART receiver, assembles little-endian words, and writes them into consecutive BRAM addresses from 0 through the BRAM write port. Loading stops at a halt word or when memory is full. Status outputs let the debug unit release the CPU once the program is resident.

## Interface
- ADDRESS_BITS, 8, BRAM address width
- DATA_BITS, 32, BRAM word width; must be a multiple of 8
- HALT_WORD, all ones (DATA_BITS wide), end-of-program marker
- clk  in  1  single clock; all state changes on posedge
- rst  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle pulse that begins a load
- i_rx_valid  in  1  i_rx_data carries a new byte this cycle
- i_rx_data  in  8  received byte
- o_write_enable  out  1  one-cycle BRAM write strobe
- o_address  out  ADDRESS_BITS  BRAM write address
- o_data  out  DATA_BITS  BRAM write data
- o_busy  out  1  load in progress
- o_done  out  1  load finished; held high
- o_error  out  1  overflow or checksum failure; held with o_done
- o_word_count  out  ADDRESS_BITS+1  number of words written

## Operation
- FSM states: IDLE, RECV, CHECK (present only with the macro), DONE.
- IDLE → RECV on i_start. This clears the address, byte index, assembly register, word count, checksum, o_done and o_error.
- RECV: each i_rx_valid byte goes into lane byte_idx. The first byte lands in bits [7:0].
- When the byte at index DATA_BITS/8-1 arrives, register o_data (the full word), o_address (the current address) and o_write_enable=1 for exactly one cycle, then increment o_word_count.
- The halt word is itself written to memory.
- After a write:
  - Word == HALT_WORD → DONE, or → CHECK when the macro is defined.
  - Otherwise, address == 2^ADDRESS_BITS-1 → DONE with o_error=1 (overflow).
  - Otherwise, address+1 and stay in RECV.
- Address arithmetic is ADDRESS_BITS wide. It never wraps, because the overflow exit happens first.
- While o_write_enable is high, the next byte may already arrive. It is accepted into a fresh word.
- i_start is ignored in RECV and CHECK.
- DONE holds o_done and o_error. i_start in DONE restarts as from IDLE.
- o_busy=1 in RECV and CHECK.
- Reset mid-load discards any partial word, issues no write, and returns all outputs to reset values.
- Reset values: o_write_enable=0, o_address=0, o_data=0, o_busy=0, o_done=0, o_error=0, o_word_count=0, state IDLE.

## Timing
- Last byte of a word sampled at edge N → o_write_enable high between edges N and N+1 → BRAM stores the word at edge N+1.
- Without the macro, o_done rises at the same edge as the halt write strobe, and o_busy falls at that edge.
- Input bytes may arrive back-to-back (one per cycle) or with arbitrary gaps. There is no backpressure.
- i_start arriving in the same cycle as i_rx_valid in IDLE: the byte is dropped. Only bytes from the following cycle onward are accepted.

## Configuration
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - The block keeps a running 8-bit XOR of every data byte, halt bytes included.
  - After the halt word it enters CHECK and waits for one more byte.
  - If that byte equals the XOR → DONE with o_error=0; otherwise → DONE with o_error=1.
  - o_done is delayed until the checksum byte has been received.
- Undefined: no CHECK state and no checksum logic. DONE follows the halt write directly.

## Structure
- Shared package: FSM state encodings, default HALT_WORD constant, byte width (8), and derived BYTES_PER_WORD = DATA_BITS/8.
- One natural sub-module: word_assembler (byte index counter plus shift/lane register, producing a word-complete pulse and the assembled word). The FSM, address counter and status logic stay in program_loader.

## Test plan
- i_start, then bytes 78 56 34 12 EF BE AD DE FF FF FF FF back-to-back → writes addr0=0x12345678, addr1=0xDEADBEEF, addr2=0xFFFFFFFF; o_done=1, o_error=0, o_word_count=3.
- Same stream with 0–5 idle cycles between bytes → identical writes and status.
- ADDRESS_BITS=2, four non-halt words → four writes at addresses 0–3, then o_done=1, o_error=1, o_word_count=4, no fifth write.
- rst low after two bytes of the first word → no write strobe, all outputs 0. A fresh i_start load then writes from address 0 correctly.
- LOADER_CHECKSUM_EN: words 0x00000001 plus halt, then checksum byte 0x01 → o_done=1, o_error=0. Checksum byte 0x02 → o_done=1, o_error=1.
- i_start pulsed mid-word in RECV → ignored, load completes normally. i_start in DONE → o_done clears and a second load begins at address 0.
